// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: funct3 load/store encodings,
// the access FSM state type and the alignment-fault predicate.
package mem_access_unit_pkg;

  localparam logic [2:0] F3Byte  = 3'b000;  // LB / SB
  localparam logic [2:0] F3Half  = 3'b001;  // LH / SH
  localparam logic [2:0] F3Word  = 3'b010;  // LW / SW
  localparam logic [2:0] F3ByteU = 3'b100;  // LBU
  localparam logic [2:0] F3HalfU = 3'b101;  // LHU

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (funct3 == F3Half || funct3 == F3HalfU) mis = addr_lo[0];
    else if (funct3 == F3Word)                 mis = (addr_lo != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for the data bus: load lane extract/extend and
// store strobe generation with byte/half replication across lanes.
module mem_align
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [1:0]            addr_lo_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [3:0]            wstrb_o,
  output logic [DATA_WIDTH-1:0] load_data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_lane = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
    unique case (funct3_i)
      F3Byte:  load_data_o = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
      F3ByteU: load_data_o = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
      F3Half:  load_data_o = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
      F3HalfU: load_data_o = {{(DATA_WIDTH-16){1'b0}}, half_lane};
      default: load_data_o = rdata_i;
    endcase
  end

  // Replicating the data lets the strobes alone pick the destination lane.
  always_comb begin
    unique case (funct3_i)
      F3Byte: begin
        wstrb_o = 4'b0001 << addr_lo_i;
        wdata_o = {(DATA_WIDTH/8){store_data_i[7:0]}};
      end
      F3Half: begin
        wstrb_o = 4'b0011 << addr_lo_i;
        wdata_o = {(DATA_WIDTH/16){store_data_i[15:0]}};
      end
      default: begin
        wstrb_o = 4'b1111;
        wdata_o = store_data_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data bus master: one bus transaction per load/store, stalling the
// pipeline until accepted. Define MISALIGN_TRAP_EN to trap misaligned H/W accesses.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            funct3M,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [3:0]            dmem_wstrb,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  input  logic                  dmem_ready,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallM,
  output logic                  MisalignM
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  req_valid, misalign, access, accept;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_wdata, load_data;
  logic [2:0]            cur_funct3;
  logic                  cur_we;

  assign req_valid = MemReadM | MemWriteM;

`ifdef MISALIGN_TRAP_EN
  assign misalign  = req_valid & is_misaligned(funct3M, ALUResultM[1:0]);
  assign MisalignM = (state_q == StIdle) & misalign;
`else
  assign misalign  = 1'b0;
  assign MisalignM = 1'b0;
`endif

  assign access = req_valid & ~misalign;
  assign accept = dmem_req & dmem_ready;

  // Live inputs drive the bus in the issuing cycle; the captured copy holds it while waiting.
  always_comb begin
    cur_addr   = addr_q;
    cur_wdata  = wdata_q;
    cur_funct3 = funct3_q;
    cur_we     = we_q;
    if (state_q == StIdle) begin
      cur_addr   = ALUResultM;
      cur_wdata  = WriteDataM;
      cur_funct3 = funct3M;
      cur_we     = MemWriteM;
    end
  end

  always_comb begin
    addr_d   = cur_addr;
    wdata_d  = cur_wdata;
    funct3_d = cur_funct3;
    we_d     = cur_we;
    rdata_d  = (accept && !cur_we) ? load_data : rdata_q;
  end

  mem_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem_align (
    .addr_lo_i   (cur_addr[1:0]),
    .funct3_i    (cur_funct3),
    .store_data_i(cur_wdata),
    .rdata_i     (dmem_rdata),
    .wdata_o     (dmem_wdata),
    .wstrb_o     (dmem_wstrb),
    .load_data_o (load_data)
  );

  assign dmem_we   = cur_we;
  assign dmem_addr = {cur_addr[ADDR_WIDTH-1:2], 2'b00};
  assign ReadDataM = rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (access) state_d = dmem_ready ? StDone : StBusy;
      StBusy:  if (dmem_ready) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // DONE drops the request so the accepted access is never reissued.
  always_comb begin
    dmem_req = 1'b0;
    StallM   = 1'b0;
    unique case (state_q)
      StIdle: begin
        dmem_req = access;
        StallM   = access;
      end
      StBusy: begin
        dmem_req = 1'b1;
        StallM   = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised scoreboard bench for mem_access_unit: the driver acts as the
// pipeline and bus slave, a negedge monitor checks bus traffic and results.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ALUResultM = '0;
  logic [31:0] WriteDataM = '0;
  logic        MemReadM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [2:0]  funct3M = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready = 1'b0;
  logic [31:0] ReadDataM;
  logic        StallM, MisalignM;

  mem_access_unit #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM),
    .MemReadM  (MemReadM),
    .MemWriteM (MemWriteM),
    .funct3M   (funct3M),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready),
    .ReadDataM (ReadDataM),
    .StallM    (StallM),
    .MisalignM (MisalignM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rd;
    int unsigned delay;
    bit          abandon;
  } txn_t;

  txn_t        sb_q[$];
  logic [31:0] model_mem [16] = '{default: '0};
  logic [31:0] resp_mem  [16] = '{default: '0};
  logic [31:0] noise = '0;
  int          checks = 0;
  int          failures = 0;
  bit          exp_mis = 1'b0;
  bit          to_flag = 1'b0;
  bit          to_seen = 1'b0;
  logic [31:0] exp_rd = '0;
  int unsigned stall_cnt = 0;

  // Bus slave: memory indexed by word address bits [5:2]; junk on rdata while not ready.
  always @(posedge clk) begin
    noise <= $urandom;
    if (rst_n && dmem_req && dmem_ready && dmem_we)
      for (int k = 0; k < 4; k++)
        if (dmem_wstrb[k]) resp_mem[dmem_addr[5:2]][8*k +: 8] <= dmem_wdata[8*k +: 8];
  end

  always_comb dmem_rdata = dmem_ready ? resp_mem[dmem_addr[5:2]] : noise;

  // Reference model: byte-lane memory, expected bus transaction and load result.
  function automatic txn_t model(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input int unsigned d);
    txn_t        t;
    int          off;
    logic [31:0] word, b, h;
    off       = int'(addr[1:0]);
    t.we      = wr;
    t.addr    = addr & 32'hFFFF_FFFC;
    t.delay   = d;
    t.abandon = 1'b0;
    t.rd      = '0;
    t.strb    = '0;
    t.wdata   = '0;
    if (wr) begin
      case (f3)
        3'b000:  begin t.strb = 4'(1 << off); t.wdata = {4{wd[7:0]}};  end
        3'b001:  begin t.strb = 4'(3 << off); t.wdata = {2{wd[15:0]}}; end
        default: begin t.strb = 4'hF;         t.wdata = wd;            end
      endcase
      for (int k = 0; k < 4; k++)
        if (t.strb[k]) model_mem[addr[5:2]][8*k +: 8] = t.wdata[8*k +: 8];
    end else if (rd) begin
      word = model_mem[addr[5:2]];
      b    = (word >> (8 * off)) & 32'hFF;
      h    = (word >> (16 * (off / 2))) & 32'hFFFF;
      case (f3)
        3'b000:  t.rd = (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
        3'b100:  t.rd = b;
        3'b001:  t.rd = (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
        3'b101:  t.rd = h;
        default: t.rd = word;
      endcase
    end
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: anything on the bus must match the oldest outstanding expectation.
  always @(negedge clk) begin
    bit busy;
    if (!rst_n) begin
      if (sb_q.size() != 0 && sb_q[0].abandon) void'(sb_q.pop_front());
      stall_cnt = 0;
      exp_rd    = '0;
    end else begin
      busy = (sb_q.size() != 0);
      chk("read_data", ReadDataM, exp_rd);
      chk("misalign", 32'(MisalignM), 32'(exp_mis));
      chk("dmem_req", 32'(dmem_req), 32'(busy));
      chk("stall", 32'(StallM), 32'(busy));
      if (busy && dmem_req) begin
        stall_cnt++;
        chk("bus_we", 32'(dmem_we), 32'(sb_q[0].we));
        chk("bus_addr", dmem_addr, sb_q[0].addr);
        if (sb_q[0].we) begin
          chk("bus_wstrb", 32'(dmem_wstrb), 32'(sb_q[0].strb));
          chk("bus_wdata", dmem_wdata, sb_q[0].wdata);
        end
        if (dmem_ready) begin
          chk("latency", stall_cnt, sb_q[0].delay + 1);
          if (!sb_q[0].we) exp_rd = sb_q[0].rd;
          void'(sb_q.pop_front());
          stall_cnt = 0;
        end
      end
      if (to_flag && !to_seen) begin
        to_seen = 1'b1;
        chk("timeout", 32'(to_flag), 32'd0);
      end
    end
  end

  // Pipeline driver: holds the MEM inputs while StallM is high, ready after d cycles.
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input int unsigned d);
    int   cyc;
    logic s;
    if (rd || wr) sb_q.push_back(model(rd, wr, f3, addr, wd, d));
    MemReadM   = rd;
    MemWriteM  = wr;
    funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = wd;
    cyc        = 0;
    forever begin
      dmem_ready = (cyc >= int'(d));
      @(negedge clk);
      s = StallM;
      @(posedge clk);
      #1;
      if (!s) break;
      cyc++;
      if (cyc > 60) begin
        to_flag = 1'b1;
        break;
      end
    end
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
  endtask

  initial begin
    logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0]  f3;
    logic [31:0] a;
    int unsigned op;
    txn_t        t;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      a = ($urandom() & 32'hFFFF_FFC0) | 32'(i << 2);
      issue(1'b0, 1'b1, 3'b010, a, $urandom(), $urandom_range(0, 2));
    end

    issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0);
    issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0);
    issue(1'b0, 1'b1, 3'b010, 32'h100, 32'h8011_2233, 1);
    issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0);
    issue(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 2);
    issue(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 0);
    issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 0);
    issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 3);
    issue(1'b1, 1'b1, 3'b000, 32'h105, 32'h0000_0077, 1);
    issue(1'b1, 1'b0, 3'b100, 32'h105, 32'h0, 0);

`ifdef MISALIGN_TRAP_EN
    exp_mis    = 1'b1;
    MemReadM   = 1'b1;
    funct3M    = 3'b010;
    ALUResultM = 32'h101;
    @(posedge clk);
    #1;
    exp_mis  = 1'b0;
    MemReadM = 1'b0;
    @(posedge clk);
    #1;
`endif

    for (int n = 0; n < 200; n++) begin
      op = $urandom_range(0, 9);
      a  = $urandom();
      if (op < 2) begin
        issue(1'b0, 1'b0, 3'b000, a, $urandom(), 0);
      end else begin
        f3 = (op < 6) ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
`ifdef MISALIGN_TRAP_EN
        if (f3 == 3'b010) a = a & 32'hFFFF_FFFC;
        else if (f3 == 3'b001 || f3 == 3'b101) a = a & 32'hFFFF_FFFE;
`endif
        issue(op < 6 || op == 9, op >= 6, f3, a, $urandom(), $urandom_range(0, 3));
      end
    end

    // Reset while the bus is stalled: the transaction is dropped with no DONE cycle.
    t = model(1'b1, 1'b0, 3'b010, 32'h140, 32'h0, 99);
    t.abandon = 1'b1;
    sb_q.push_back(t);
    MemReadM   = 1'b1;
    funct3M    = 3'b010;
    ALUResultM = 32'h140;
    dmem_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n    = 1'b0;
    MemReadM = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the data path width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the byte address width.
REQ-003 Port clk  in  1  clock; all state updates on the rising edge.
REQ-004 Port rst_n  in  1  reset: synchronous, active-low.
REQ-005 Port ALUResultM  in  ADDR_WIDTH  effective byte address of the access.
REQ-006 Port WriteDataM  in  DATA_WIDTH  store data, right-aligned.
REQ-007 Port MemReadM  in  1  load request.
REQ-008 Port MemWriteM  in  1  store request.
REQ-009 Port funct3M  in  3  access type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000 SB, 001 SH, 010 SW.
REQ-010 Port dmem_req  out  1  bus request, held until accepted.
REQ-011 Port dmem_we  out  1  bus write enable.
REQ-012 Port dmem_addr  out  ADDR_WIDTH  word-aligned address, bits [1:0] = 00.
REQ-013 Port dmem_wdata  out  DATA_WIDTH  lane-shifted store data.
REQ-014 Port dmem_wstrb  out  4  byte-lane strobes.
REQ-015 Port dmem_rdata  in  DATA_WIDTH  bus read word.
REQ-016 Port dmem_ready  in  1  bus accepts the request or returns data this cycle.
REQ-017 Port ReadDataM  out  DATA_WIDTH  aligned and extended load result for the MEM/WB register.
REQ-018 Port StallM  out  1  freezes the upstream pipeline and MEM/WB while high.
REQ-019 Port MisalignM  out  1  misaligned-access exception pulse.

Function
REQ-020 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-021 In IDLE with an access (MemReadM|MemWriteM, aligned), the block SHALL assert dmem_req combinationally.
REQ-022 If dmem_ready=0 in that cycle, the FSM SHALL move to BUSY; otherwise it SHALL move to DONE.
REQ-023 In BUSY, the block SHALL hold dmem_req and all bus outputs stable, and SHALL move to DONE on the first cycle with dmem_ready=1.
REQ-024 StallM SHALL be high in the IDLE-with-access cycle and in every BUSY cycle, and low in DONE; minimum access latency is 2 cycles.
REQ-025 In DONE, the block SHALL drop dmem_req and return to IDLE next cycle, so an access is never repeated.
REQ-026 On a load, dmem_rdata SHALL be captured into a register on the accepting cycle; ReadDataM SHALL be that register.
REQ-027 The load lane SHALL be selected by addr[1:0]: LB/LBU sign- or zero-extend byte addr[1:0]; LH/LHU extend halfword addr[1].
REQ-028 ReadDataM SHALL hold its value until the next load completes; stores SHALL not change it.
REQ-029 For stores, wstrb SHALL be SB 0001<<addr[1:0], SH 0011<<addr[1:0], SW 1111; wdata SHALL replicate the byte or half across lanes.
REQ-030 MemReadM and MemWriteM both high SHALL be treated as a store.
REQ-031 With no access, dmem_req=0 and StallM=0.

Reset
REQ-032 With rst_n=0 at a clock edge, the block SHALL set: state IDLE, ReadDataM 0, MisalignM 0, dmem_req 0, StallM 0 (outputs valid one cycle after reset when inputs are idle).
REQ-033 Reset mid-access (BUSY) SHALL abandon the transaction without a DONE cycle.

Configuration
REQ-034 Macro MISALIGN_TRAP_EN defined: a misaligned LH/LHU/SH (addr[0]=1) or LW/SW (addr[1:0]!=0) SHALL issue no bus request, SHALL pulse MisalignM for one cycle, and SHALL keep StallM low.
REQ-035 Macro MISALIGN_TRAP_EN undefined: MisalignM SHALL be tied 0 and the access SHALL proceed to the word-aligned address, using the lanes per REQ-027/REQ-029.

Structure
REQ-036 The shared package SHALL hold the funct3 load/store encodings and the FSM state enum.
REQ-037 The lane extract/extend and strobe/replicate logic SHALL be one combinational sub-module, mem_align.

Verification
REQ-038 LW at 0x100, memory word 0xDEADBEEF, ready=1 immediately -> StallM high 1 cycle, then ReadDataM=0xDEADBEEF.
REQ-039 LB at 0x103, word 0x80112233 -> ReadDataM=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-040 SH at 0x202, data 0x0000ABCD -> wstrb=1100, wdata=0xABCDABCD, dmem_addr=0x200.
REQ-041 LW with ready delayed 3 cycles -> StallM high 4 cycles, bus outputs stable, exactly one accept.
REQ-042 MISALIGN_TRAP_EN: LW at 0x101 -> MisalignM=1 for one cycle, dmem_req=0, StallM=0.
REQ-043 rst_n=0 while in BUSY -> next cycle state IDLE, dmem_req=0, StallM=0, ReadDataM=0.
